// File: rtl/hex_msg_scroller.sv
// hex_msg_scroller: message buffer and scroll sequencer for four 3-bit glyph
// decoders (HEX3..HEX0).
//
// Characters are loaded one at a time from SW. The message is then scrolled
// across the displays, one step every TICK_DIV clock cycles.
//
// Optional build macro SCROLL_BLINK_EN. When it is defined, the displays blink
// while the scroller is paused. When it is undefined, a pause freezes the
// displays and no blink logic is built.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | buffer empty, waiting for the first character
// LOAD   | accepting characters; display previews buf[0..3]
// RUN    | divider counting, offset steps on every divider wrap
// PAUSE  | offset frozen (divider frozen unless blinking is built in)

module hex_msg_scroller #(
  parameter int TICK_DIV = 50000000,
  parameter int MSG_LEN  = 8,
  parameter int PTR_W    = 3
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [2:0]       SW,
  input  logic             load,
  input  logic             run,
  input  logic             dir,
  input  logic             clear,
  output logic [2:0]       CODE3,
  output logic [2:0]       CODE2,
  output logic [2:0]       CODE1,
  output logic [2:0]       CODE0,
  output logic [PTR_W:0]   wr_ptr,
  output logic             full,
  output logic             tick
);

  localparam int                 DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [PTR_W:0]     PTR_FULL = (PTR_W+1)'(MSG_LEN);
  localparam logic [2:0]         BLANK    = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic [2:0]         msg_buf [MSG_LEN];
  logic [PTR_W-1:0]   offset_q;
  logic [DIV_W-1:0]   div_q;

  // datapath controls decoded by the FSM
  logic               wr_en;
  logic [PTR_W-1:0]   wr_addr;
  logic               ptr_one;
  logic               flush;
  logic               restart;
  logic               cnt_en;
  logic               div_wrap;
  logic               step;

  logic [PTR_W-1:0]   idx3;
  logic [PTR_W-1:0]   idx2;
  logic [PTR_W-1:0]   idx1;
  logic [PTR_W-1:0]   idx0;

`ifdef SCROLL_BLINK_EN
  logic               blink_q;
  logic               blink_tgl;
  logic               blink_clr;
`endif

  assign full     = (wr_ptr == PTR_FULL);
  assign div_wrap = cnt_en && (div_q == DIV_LAST);

  // Display window: four consecutive slots starting at offset. The index
  // arithmetic wraps naturally because MSG_LEN is a power of two.
  assign idx3 = offset_q;
  assign idx2 = offset_q + PTR_W'(1);
  assign idx1 = offset_q + PTR_W'(2);
  assign idx0 = offset_q + PTR_W'(3);

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and control decode. clear overrides every other input.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_addr = wr_ptr[PTR_W-1:0];
    ptr_one = 1'b0;
    flush   = 1'b0;
    restart = 1'b0;
    cnt_en  = 1'b0;
    step    = 1'b0;
`ifdef SCROLL_BLINK_EN
    blink_tgl = 1'b0;
    blink_clr = 1'b0;
`endif
    if (clear) begin
      flush   = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            ptr_one = 1'b1;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          // A load and a run in the same cycle both take effect.
          if (load && !full) wr_en = 1'b1;
          if (run) begin
            restart = 1'b1;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (!run) begin
            state_d = S_PAUSE;
          end else begin
            cnt_en = 1'b1;
            step   = (div_q == DIV_LAST);
          end
        end
        S_PAUSE: begin
          if (run) begin
            state_d = S_RUN;
`ifdef SCROLL_BLINK_EN
            blink_clr = 1'b1;
`endif
          end else begin
`ifdef SCROLL_BLINK_EN
            // The divider keeps running only to pace the blink.
            cnt_en    = 1'b1;
            blink_tgl = (div_q == DIV_LAST);
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Message buffer. Empty slots hold BLANK so that short messages scroll
  // through a visible gap.
  always_ff @(posedge CLOCK_50) begin
    if (RESET || flush) begin
      for (int i = 0; i < MSG_LEN; i++) msg_buf[i] <= BLANK;
    end else if (wr_en) begin
      msg_buf[wr_addr] <= SW;
    end
  end

  // Write pointer. It counts the characters loaded and saturates at MSG_LEN,
  // because writes are refused once the buffer is full.
  always_ff @(posedge CLOCK_50) begin
    if (RESET || flush) wr_ptr <= '0;
    else if (ptr_one)   wr_ptr <= (PTR_W+1)'(1);
    else if (wr_en)     wr_ptr <= wr_ptr + (PTR_W+1)'(1);
  end

  // Scroll-rate divider. It counts 0..TICK_DIV-1 and holds its count while
  // frozen, so that a resumed run finishes the interrupted interval.
  always_ff @(posedge CLOCK_50) begin
    if (RESET || flush || restart) div_q <= '0;
    else if (cnt_en)               div_q <= div_wrap ? '0 : div_q + DIV_W'(1);
  end

  // Scroll offset. dir is sampled only in the step cycle.
  always_ff @(posedge CLOCK_50) begin
    if (RESET || flush || restart) offset_q <= '0;
    else if (step)                 offset_q <= dir ? offset_q - PTR_W'(1)
                                                   : offset_q + PTR_W'(1);
  end

  // tick goes high in the same cycle that the new offset is visible.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) tick <= 1'b0;
    else       tick <= step;
  end

`ifdef SCROLL_BLINK_EN
  // Blink phase. It toggles on each divider wrap while paused and is cleared
  // when the scroller leaves PAUSE.
  always_ff @(posedge CLOCK_50) begin
    if (RESET || flush || blink_clr) blink_q <= 1'b0;
    else if (blink_tgl)              blink_q <= ~blink_q;
  end
`endif

  // Registered display codes, one cycle behind the buffer and offset.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      CODE3 <= BLANK;
      CODE2 <= BLANK;
      CODE1 <= BLANK;
      CODE0 <= BLANK;
    end else begin
`ifdef SCROLL_BLINK_EN
      if (blink_q) begin
        CODE3 <= BLANK;
        CODE2 <= BLANK;
        CODE1 <= BLANK;
        CODE0 <= BLANK;
      end else begin
        CODE3 <= msg_buf[idx3];
        CODE2 <= msg_buf[idx2];
        CODE1 <= msg_buf[idx1];
        CODE0 <= msg_buf[idx0];
      end
`else
      CODE3 <= msg_buf[idx3];
      CODE2 <= msg_buf[idx2];
      CODE1 <= msg_buf[idx1];
      CODE0 <= msg_buf[idx0];
`endif
    end
  end

endmodule

// File: tb/tb_hex_msg_scroller.sv
// Scoreboard bench for hex_msg_scroller in the default build (no blink).
// The stimulus process drives inputs on the falling edge and pushes the
// model's prediction for the following rising edge. The monitor pops one
// prediction after each rising edge and compares it with the DUT.

module tb_hex_msg_scroller;

  localparam int TICK_DIV = 4;
  localparam int MSG_LEN  = 8;
  localparam int PTR_W    = 3;

  logic             clk = 1'b0;
  logic             RESET = 1'b0;
  logic [2:0]       SW = 3'd0;
  logic             load = 1'b0;
  logic             run = 1'b0;
  logic             dir = 1'b0;
  logic             clear = 1'b0;
  logic [2:0]       CODE3, CODE2, CODE1, CODE0;
  logic [PTR_W:0]   wr_ptr;
  logic             full;
  logic             tick;

  hex_msg_scroller #(.TICK_DIV(TICK_DIV), .MSG_LEN(MSG_LEN), .PTR_W(PTR_W)) dut (
    .CLOCK_50(clk), .RESET(RESET), .SW(SW), .load(load), .run(run), .dir(dir),
    .clear(clear), .CODE3(CODE3), .CODE2(CODE2), .CODE1(CODE1), .CODE0(CODE0),
    .wr_ptr(wr_ptr), .full(full), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] c3, c2, c1, c0;
    logic [3:0] wp;
    logic       fl, tk;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: the message is a queue of loaded characters, and the
  // scroll position is an integer window start.
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3;
  int         mode = M_IDLE;
  logic [2:0] msg[$];
  int         win = 0;
  int         elapsed = 0;

  function automatic logic [2:0] glyph(int slot);
    return (slot < msg.size()) ? msg[slot] : 3'd7;
  endfunction

  task automatic cyc(input bit r, input bit ld, input logic [2:0] sw,
                     input bit rn, input bit d, input bit clr);
    exp_t e;
    @(negedge clk);
    RESET = r; load = ld; SW = sw; run = rn; dir = d; clear = clr;
    if (r) begin
      e.c3 = 3'd7; e.c2 = 3'd7; e.c1 = 3'd7; e.c0 = 3'd7;
    end else begin
      e.c3 = glyph(win % MSG_LEN);
      e.c2 = glyph((win + 1) % MSG_LEN);
      e.c1 = glyph((win + 2) % MSG_LEN);
      e.c0 = glyph((win + 3) % MSG_LEN);
    end
    e.tk = 1'b0;
    if (r || clr) begin
      msg.delete(); mode = M_IDLE; win = 0; elapsed = 0;
    end else begin
      case (mode)
        M_IDLE: if (ld) begin msg.push_back(sw); mode = M_LOAD; end
        M_LOAD: begin
          if (ld && msg.size() < MSG_LEN) msg.push_back(sw);
          if (rn) begin mode = M_RUN; win = 0; elapsed = 0; end
        end
        M_RUN: begin
          if (!rn) mode = M_PAUSE;
          else begin
            elapsed++;
            if (elapsed == TICK_DIV) begin
              elapsed = 0;
              e.tk = 1'b1;
              win = d ? (win + MSG_LEN - 1) % MSG_LEN : (win + 1) % MSG_LEN;
            end
          end
        end
        default: if (rn) mode = M_RUN;
      endcase
    end
    e.wp = 4'(msg.size());
    e.fl = (msg.size() == MSG_LEN);
    expq.push_back(e);
  endtask

  // Monitor: sample shortly after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        vectors++;
        if ({CODE3, CODE2, CODE1, CODE0, wr_ptr, full, tick} !==
            {e.c3, e.c2, e.c1, e.c0, e.wp, e.fl, e.tk}) begin
          miscompares++;
          $display("FAIL vec%0d t=%0t codes/wr_ptr/full/tick got %0d%0d%0d%0d/%0d/%0b/%0b want %0d%0d%0d%0d/%0d/%0b/%0b",
                   vectors, $time, CODE3, CODE2, CODE1, CODE0, wr_ptr, full, tick,
                   e.c3, e.c2, e.c1, e.c0, e.wp, e.fl, e.tk);
        end
      end
    end
  end

  initial begin
    bit rn;
    logic [2:0] seq[5];
    seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd2; seq[3] = 3'd2; seq[4] = 3'd3;

    // reset held for two cycles
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);   // run ignored in IDLE

    // load 0,1,2,2,3 with gaps, preview is live
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, seq[i], 0, 0, 0);
      cyc(0, 0, 3'd5, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0);

    // scroll left through more than one full wrap
    for (int i = 0; i < 8 * TICK_DIV + 3; i++) cyc(0, 0, 0, 1, 0, 0);
    // reverse direction, then pause mid-interval, then resume
    for (int i = 0; i < 2 * TICK_DIV + 1; i++) cyc(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 3'd4, 0, 1, 0);   // load ignored in PAUSE
    for (int i = 0; i < 2 * TICK_DIV + 2; i++) cyc(0, 0, 0, 1, 1, 0);

    // clear then load nine characters back to back, ninth refused
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(0, 1, 3'(i % 7), 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // load and run in the same cycle while not full
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 3'd6, 0, 0, 0);
    cyc(0, 1, 3'd5, 0, 0, 0);
    cyc(0, 1, 3'd4, 1, 0, 0);
    for (int i = 0; i < 3 * TICK_DIV; i++) cyc(0, 1, 3'd1, 1, 0, 0);

    // clear together with load during RUN
    cyc(0, 1, 3'd2, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // reset in the middle of a scroll
    cyc(0, 1, 3'd3, 0, 0, 0);
    cyc(0, 1, 3'd0, 1, 0, 0);
    for (int i = 0; i < TICK_DIV + 1; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // randomized traffic
    rn = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) rn = ~rn;
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 2) == 0),
          3'($urandom_range(0, 7)), rn, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 59) == 0));
    end
    cyc(0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #3;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain queue left %0d required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hex_msg_scroller.md
Name: hex_msg_scroller

Overview:
Sequencer that feeds the four 3-bit glyph decoders driving HEX3..HEX0.
- Holds a message buffer of MSG_LEN glyph codes, loaded one character at a time from SW[2:0].
- Scrolls the message across the four displays at a divided-clock rate.
- Outputs one 3-bit code per display. Each output connects straight to a decoder's num input.
- Glyph codes 0-6 are letters. Code 7 renders blank on the decoder.

Parameters:
TICK_DIV, 50000000, clock cycles per scroll step (1 s at 50 MHz); minimum 2
MSG_LEN, 8, buffer depth in characters; power of two, 4..16
PTR_W, 3, log2(MSG_LEN)

Ports:
CLOCK_50  in  1  system clock; all logic on its rising edge
RESET  in  1  synchronous, active-high reset
SW  in  3  glyph code to load
load  in  1  single-cycle strobe: write SW at wr_ptr
run  in  1  level: 1 = scroll, 0 = hold
dir  in  1  0 = scroll left (offset+1), 1 = scroll right (offset-1)
clear  in  1  single-cycle strobe: blank buffer, return to IDLE
CODE3  out  3  code for leftmost display (HEX3)
CODE2  out  3  code for HEX2
CODE1  out  3  code for HEX1
CODE0  out  3  code for rightmost display (HEX0)
wr_ptr  out  PTR_W+1  characters loaded so far, 0..MSG_LEN
full  out  1  wr_ptr == MSG_LEN
tick  out  1  one-cycle pulse on each scroll step

Behaviour:
Reset (RESET=1 at an edge):
- State = IDLE.
- All buffer entries = 7.
- wr_ptr = 0, offset = 0, divider = 0.
- CODE3..CODE0 = 7, tick = 0, full = 0.
- Reset mid-scroll behaves identically; no partial state survives.

States:
- IDLE: on load, write buf[0]=SW, wr_ptr=1, go to LOAD. run is ignored.
- LOAD: on load with !full, write buf[wr_ptr]=SW and increment wr_ptr. With full, load is ignored; wr_ptr saturates at MSG_LEN. On run=1, go to RUN with offset=0 and divider=0. When load and run occur in the same cycle, the write is performed and the transition is taken.
- RUN: divider counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0, tick=1, and offset updates. dir is sampled in the tick cycle: dir=0 gives offset=(offset+1) mod MSG_LEN; dir=1 gives offset=(offset-1) mod MSG_LEN. On run=0, go to PAUSE.
- PAUSE: divider and offset are frozen. On run=1, return to RUN; the divider resumes from its held count.

Ordering and priority:
- clear takes priority over all other inputs in every state. It blanks the buffer and sets wr_ptr=0, offset=0, divider=0, and state=IDLE.
- load in RUN or PAUSE is ignored.

Display mapping:
- CODE3 = buf[offset]
- CODE2 = buf[offset+1]
- CODE1 = buf[offset+2]
- CODE0 = buf[offset+3]
- All indices are mod MSG_LEN. Unloaded slots hold 7 and show blank.
- In IDLE and LOAD, offset=0, so the displays preview buf[0..3] live.

Latency:
- Outputs are registered. CODEx reflects a buffer or offset change one cycle after the edge that made it.
- tick is asserted in the same cycle as the offset register update, so CODEx changes one cycle after tick.
- Blank wrap gap: a message shorter than MSG_LEN scrolls through its blank slots.

Optional Feature:
Macro SCROLL_BLINK_EN.
- Defined: in PAUSE the divider keeps running, but offset is not updated. On each divider wrap a blink flag toggles. While blink=1, CODE3..CODE0 = 7. Leaving PAUSE clears blink, and the displays show content on the next cycle. tick is still not pulsed in PAUSE.
- Undefined: PAUSE freezes the divider and displays statically. No blink logic is synthesized.

Test Plan:
1. TICK_DIV=4. Hold RESET 2 cycles -> CODE3..0=7, wr_ptr=0, full=0, tick=0.
2. Load 0,1,2,2,3 (one strobe each) -> wr_ptr=5, full=0. One cycle after the 4th load: CODE3..0 = 0,1,2,2.
3. From test 2, run=1, dir=0 -> tick every 4 cycles. After the 1st tick, CODE3..0 = 1,2,2,3. After 4 ticks: 3,7,7,7. After 8 ticks: 0,1,2,2 (wrap).
4. Mid-run, set dir=1 at offset=2 -> next tick gives offset=1, CODE3..0 = 1,2,2,3. Set run=0 for 10 cycles -> no tick and outputs hold; without SCROLL_BLINK_EN they stay static. Set run=1 -> the next tick arrives after the remaining divider count.
5. Load 9 characters -> wr_ptr=8, full=1, 9th ignored. Assert load and run in the same cycle while not full -> write occurs and state enters RUN.
6. Assert clear and load together during RUN -> one cycle later all CODE=7, wr_ptr=0, state IDLE. Assert RESET during RUN -> same result, tick=0.
